// File: rtl/mips_cpu_bus_core.sv
// Multicycle MIPS32 subset core sharing one Avalon-style bus for fetch and data.
// Runs from RESET_VECTOR until it jumps to address 0, then halts with active low.
module mips_cpu_bus_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] EXEC  = 3'd1;
  localparam logic [2:0] MEM   = 3'd2;
  localparam logic [2:0] WB    = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [2:0]  state_r;
  logic [31:0] pc_r, npc_r, ir_r, maddr_r, wdata_r;
  logic [31:0] gpr_r [32];

  logic [31:0] instr_s, rs_val_s, rt_val_s, imm_se_s, imm_ze_s, slot_s, link_s;
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, sh_s;
  logic        alu_we_s, taken_s, is_ld_s, is_st_s;
  logic [4:0]  alu_rd_s;
  logic [31:0] alu_val_s, target_s;
  logic        reg_we_s;
  logic [4:0]  reg_rd_s;
  logic [31:0] reg_val_s;

  // The instruction is only on readdata during EXEC; later states use the latched copy.
  assign instr_s  = (state_r == EXEC) ? readdata : ir_r;
  assign op_s     = instr_s[31:26];
  assign rs_s     = instr_s[25:21];
  assign rt_s     = instr_s[20:16];
  assign rd_s     = instr_s[15:11];
  assign sh_s     = instr_s[10:6];
  assign funct_s  = instr_s[5:0];
  assign rs_val_s = gpr_r[rs_s];
  assign rt_val_s = gpr_r[rt_s];
  assign imm_se_s = {{16{instr_s[15]}}, instr_s[15:0]};
  assign imm_ze_s = {16'h0000, instr_s[15:0]};
  assign slot_s   = pc_r + 32'd4;
  assign link_s   = pc_r + 32'd8;

  // Instruction decode and execute
  always_comb begin
    alu_we_s  = 1'b0;
    alu_rd_s  = rt_s;
    alu_val_s = 32'h0000_0000;
    taken_s   = 1'b0;
    target_s  = slot_s + {imm_se_s[29:0], 2'b00};
    is_ld_s   = 1'b0;
    is_st_s   = 1'b0;
    case (op_s)
      6'h00: begin
        alu_we_s = 1'b1;
        alu_rd_s = rd_s;
        case (funct_s)
          6'h00: alu_val_s = rt_val_s << sh_s;
          6'h02: alu_val_s = rt_val_s >> sh_s;
          6'h03: alu_val_s = 32'($signed(rt_val_s) >>> sh_s);
          6'h04: alu_val_s = rt_val_s << rs_val_s[4:0];
          6'h06: alu_val_s = rt_val_s >> rs_val_s[4:0];
          6'h07: alu_val_s = 32'($signed(rt_val_s) >>> rs_val_s[4:0]);
          6'h08: begin alu_we_s = 1'b0; taken_s = 1'b1; target_s = rs_val_s; end
          6'h09: begin alu_val_s = link_s; taken_s = 1'b1; target_s = rs_val_s; end
          6'h21: alu_val_s = rs_val_s + rt_val_s;
          6'h23: alu_val_s = rs_val_s - rt_val_s;
          6'h24: alu_val_s = rs_val_s & rt_val_s;
          6'h25: alu_val_s = rs_val_s | rt_val_s;
          6'h26: alu_val_s = rs_val_s ^ rt_val_s;
          6'h27: alu_val_s = ~(rs_val_s | rt_val_s);
          6'h2A: alu_val_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          6'h2B: alu_val_s = {31'd0, rs_val_s < rt_val_s};
          default: alu_we_s = 1'b0;
        endcase
      end
      6'h02: begin taken_s = 1'b1; target_s = {slot_s[31:28], instr_s[25:0], 2'b00}; end
      6'h03: begin
        taken_s = 1'b1; target_s = {slot_s[31:28], instr_s[25:0], 2'b00};
        alu_we_s = 1'b1; alu_rd_s = 5'd31; alu_val_s = link_s;
      end
      6'h04: taken_s = (rs_val_s == rt_val_s);
      6'h05: taken_s = (rs_val_s != rt_val_s);
      6'h06: taken_s = rs_val_s[31] | (rs_val_s == 32'h0000_0000);
      6'h07: taken_s = ~rs_val_s[31] & (rs_val_s != 32'h0000_0000);
      6'h09: begin alu_we_s = 1'b1; alu_val_s = rs_val_s + imm_se_s; end
      6'h0A: begin alu_we_s = 1'b1; alu_val_s = {31'd0, $signed(rs_val_s) < $signed(imm_se_s)}; end
      6'h0B: begin alu_we_s = 1'b1; alu_val_s = {31'd0, rs_val_s < imm_se_s}; end
      6'h0C: begin alu_we_s = 1'b1; alu_val_s = rs_val_s & imm_ze_s; end
      6'h0D: begin alu_we_s = 1'b1; alu_val_s = rs_val_s | imm_ze_s; end
      6'h0E: begin alu_we_s = 1'b1; alu_val_s = rs_val_s ^ imm_ze_s; end
      6'h0F: begin alu_we_s = 1'b1; alu_val_s = {instr_s[15:0], 16'h0000}; end
      6'h23: is_ld_s = 1'b1;
      6'h2B: is_st_s = 1'b1;
      default: alu_we_s = 1'b0;
    endcase
  end

  // Register-file write port: ALU results in EXEC, load data in WB
  always_comb begin
    reg_we_s  = 1'b0;
    reg_rd_s  = 5'd0;
    reg_val_s = 32'h0000_0000;
    if (state_r == EXEC) begin
      reg_we_s  = alu_we_s;
      reg_rd_s  = alu_rd_s;
      reg_val_s = alu_val_s;
    end else if (state_r == WB) begin
      reg_we_s  = 1'b1;
      reg_rd_s  = ir_r[20:16];
      reg_val_s = readdata;
    end else begin
      reg_we_s  = 1'b0;
    end
  end

  // General-purpose registers; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr_r[i] <= 32'h0000_0000;
    end else if (reg_we_s && (reg_rd_s != 5'd0)) begin
      gpr_r[reg_rd_s] <= reg_val_s;
    end
  end

  // Control FSM, PC / delay-slot PC and memory-stage operand latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
      pc_r    <= RESET_VECTOR;
      npc_r   <= RESET_VECTOR + 32'd4;
      ir_r    <= 32'h0000_0000;
      maddr_r <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        FETCH: begin
          if (pc_r == 32'h0000_0000) state_r <= HALT;
          else if (!waitrequest)     state_r <= EXEC;
        end
        EXEC: begin
          ir_r <= readdata;
          if (is_ld_s || is_st_s) begin
            maddr_r <= rs_val_s + imm_se_s;
            wdata_r <= rt_val_s;
            state_r <= MEM;
          end else begin
            pc_r    <= npc_r;
            npc_r   <= taken_s ? target_s : npc_r + 32'd4;
            state_r <= FETCH;
          end
        end
        MEM: begin
          if (!waitrequest) begin
            if (is_ld_s) begin
              state_r <= WB;
            end else begin
              pc_r    <= npc_r;
              npc_r   <= npc_r + 32'd4;
              state_r <= FETCH;
            end
          end
        end
        WB: begin
          pc_r    <= npc_r;
          npc_r   <= npc_r + 32'd4;
          state_r <= FETCH;
        end
        HALT:    state_r <= HALT;
        default: state_r <= FETCH;
      endcase
    end
  end

  // Bus requests drop the instant reset is asserted, not at the next edge.
  assign read        = reset & (((state_r == FETCH) && (pc_r != 32'h0000_0000)) ||
                                ((state_r == MEM) && is_ld_s));
  assign write       = reset & (state_r == MEM) & is_st_s;
  assign address     = (state_r == MEM) ? {maddr_r[31:2], 2'b00} : {pc_r[31:2], 2'b00};
  assign writedata   = wdata_r;
  assign byteenable  = 4'b1111;
  assign active      = (state_r != HALT);
  assign register_v0 = gpr_r[2];

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed bench for mips_cpu_bus_core with a one-cycle-latency bus memory model.
module tb_mips_cpu_bus_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  logic [31:0] rom [64];
  logic [31:0] st_m [64];
  logic        st_v [64];
  logic        stall_en = 1'b0;
  int          wcnt = 0;
  int          checks = 0, errors = 0;
  int          hold_errs = 0, stall_seen = 0, conflict = 0;
  logic        held = 1'b0;
  logic [31:0] h_addr, h_wd;
  logic        h_rd, h_wr;

  mips_cpu_bus_core dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  assign waitrequest = stall_en && (read || write) && (wcnt < 3);

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'hBFC00000;
    if (d < 32'd256) return int'(d[7:2]);
    return -1;
  endfunction

  // Bus slave: stores land in st_m, reads return stored data over the program image
  always @(posedge clk) begin
    if (!reset) begin
      wcnt <= 0;
      held <= 1'b0;
      readdata <= 32'h0;
      for (int i = 0; i < 64; i++) st_v[i] <= 1'b0;
    end else begin
      if (read && write) conflict++;
      if (held && (address !== h_addr || read !== h_rd || write !== h_wr || writedata !== h_wd))
        hold_errs++;
      if ((read || write) && waitrequest) begin
        wcnt <= wcnt + 1;
        stall_seen++;
        held <= 1'b1;
        h_addr <= address; h_rd <= read; h_wr <= write; h_wd <= writedata;
      end else begin
        held <= 1'b0;
        wcnt <= 0;
        if (read) begin
          if (widx(address) >= 0)
            readdata <= st_v[widx(address)] ? st_m[widx(address)] : rom[widx(address)];
          else
            readdata <= 32'h0;
        end
        if (write && widx(address) >= 0) begin
          st_m[widx(address)] <= writedata;
          st_v[widx(address)] <= 1'b1;
        end
      end
    end
  end

  task automatic clear_rom;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic load_ls;
    clear_rom();
    rom[0] = 32'h3C08BFC0; rom[1] = 32'h8D09002C; rom[2] = 32'h00000008; rom[3] = 32'hAD090030;
    rom[11] = 32'h0000A3F3;
  endtask

  task automatic load_v0;
    clear_rom();
    rom[0] = 32'h3C021234; rom[1] = 32'h34425678; rom[2] = 32'h00000008; rom[3] = 32'h00000000;
  endtask

  task automatic load_br;
    clear_rom();
    rom[0] = 32'h10000002; rom[1] = 32'h24020001; rom[2] = 32'h24420004;
    rom[3] = 32'h24420010; rom[4] = 32'h00000008; rom[5] = 32'h00000000;
  endtask

  task automatic restart;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (active === 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    load_v0();
    @(negedge clk) reset = 1'b0;
    #1;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rst_active got %b exp 1", active); end
    checks++; if (read !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL rst_rw got %b%b exp 00", read, write); end
    checks++; if (byteenable !== 4'b1111) begin errors++; $display("FAIL rst_be got %h exp f", byteenable); end
    checks++; if (writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", writedata); end
    checks++; if (address !== 32'hBFC00000) begin errors++; $display("FAIL rst_addr got %h exp bfc00000", address); end
    checks++; if (register_v0 !== 32'h0) begin errors++; $display("FAIL rst_v0 got %h exp 0", register_v0); end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rel_active got %b exp 1", active); end
    checks++; if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC00000) begin
      errors++; $display("FAIL first_op got r%b w%b %h exp r1 w0 bfc00000", read, write, address);
    end
  endtask

  task automatic test_register_obs;
    int cyc;
    load_v0();
    restart();
    run_to_halt(cyc);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL v0_halt got %b exp 0", active); end
    checks++; if (register_v0 !== 32'h12345678) begin errors++; $display("FAIL v0_val got %h exp 12345678", register_v0); end
  endtask

  task automatic test_load_store;
    int cyc;
    load_ls();
    restart();
    run_to_halt(cyc);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL ls_halt got %b exp 0 after %0d", active, cyc); end
    checks++; if (st_v[12] !== 1'b1 || st_m[12] !== 32'h0000A3F3) begin
      errors++; $display("FAIL ls_store got v%b %h exp v1 0000a3f3", st_v[12], st_m[12]);
    end
  endtask

  task automatic test_alu;
    int cyc;
    clear_rom();
    rom[0]  = 32'h3C08BFC0; rom[1]  = 32'h2403FFF8; rom[2]  = 32'h24040003; rom[3]  = 32'h00032843;
    rom[4]  = 32'hAD050080; rom[5]  = 32'h0064302A; rom[6]  = 32'h0064382B; rom[7]  = 32'hAD060084;
    rom[8]  = 32'hAD070088; rom[9]  = 32'h00831023; rom[10] = 32'h00844804; rom[11] = 32'hAD09008C;
    rom[12] = 32'h00005027; rom[13] = 32'hAD0A0090; rom[14] = 32'h24000005; rom[15] = 32'hAD000094;
    rom[16] = 32'h00000008; rom[17] = 32'h00000000;
    restart();
    run_to_halt(cyc);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL alu_halt got %b exp 0", active); end
    checks++; if (st_m[32] !== 32'hFFFFFFFC) begin errors++; $display("FAIL sra got %h exp fffffffc", st_m[32]); end
    checks++; if (st_m[33] !== 32'h1) begin errors++; $display("FAIL slt got %h exp 1", st_m[33]); end
    checks++; if (st_m[34] !== 32'h0) begin errors++; $display("FAIL sltu got %h exp 0", st_m[34]); end
    checks++; if (st_m[35] !== 32'd24) begin errors++; $display("FAIL sllv got %h exp 18", st_m[35]); end
    checks++; if (st_m[36] !== 32'hFFFFFFFF) begin errors++; $display("FAIL nor got %h exp ffffffff", st_m[36]); end
    checks++; if (st_m[37] !== 32'h0) begin errors++; $display("FAIL r0_write got %h exp 0", st_m[37]); end
    checks++; if (register_v0 !== 32'd11) begin errors++; $display("FAIL subu got %h exp b", register_v0); end
  endtask

  task automatic test_branch;
    int cyc;
    load_br();
    restart();
    run_to_halt(cyc);
    checks++; if (register_v0 !== 32'd17) begin errors++; $display("FAIL branch_v0 got %0d exp 17", register_v0); end
  endtask

  task automatic test_wait_states;
    int cyc;
    stall_en = 1'b1;
    hold_errs = 0;
    stall_seen = 0;
    load_ls();
    restart();
    run_to_halt(cyc);
    checks++; if (st_v[12] !== 1'b1 || st_m[12] !== 32'h0000A3F3) begin
      errors++; $display("FAIL ws_store got v%b %h exp v1 0000a3f3", st_v[12], st_m[12]);
    end
    load_br();
    restart();
    run_to_halt(cyc);
    checks++; if (register_v0 !== 32'd17) begin errors++; $display("FAIL ws_branch got %0d exp 17", register_v0); end
    checks++; if (hold_errs !== 0) begin errors++; $display("FAIL ws_hold got %0d exp 0", hold_errs); end
    checks++; if (stall_seen < 3) begin errors++; $display("FAIL ws_seen got %0d exp >=3", stall_seen); end
    stall_en = 1'b0;
  endtask

  task automatic test_halt;
    int cyc, bad;
    load_v0();
    restart();
    run_to_halt(cyc);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (read !== 1'b0 || write !== 1'b0 || active !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_idle got %0d exp 0", bad); end
    @(negedge clk) reset = 1'b0;
    #1;
    checks++; if (register_v0 !== 32'h0) begin errors++; $display("FAIL halt_rst_v0 got %h exp 0", register_v0); end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++; if (active !== 1'b1 || read !== 1'b1 || address !== 32'hBFC00000) begin
      errors++; $display("FAIL halt_restart got a%b r%b %h exp a1 r1 bfc00000", active, read, address);
    end
  endtask

  initial begin
    test_reset();
    test_register_obs();
    test_load_store();
    test_alu();
    test_branch();
    test_wait_states();
    test_halt();
    checks++; if (conflict !== 0) begin errors++; $display("FAIL rw_conflict got %0d exp 0", conflict); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_cpu_bus_core.md
Name: mips_cpu_bus_core

Overview:
- Multicycle MIPS32 little-subset CPU with a single Avalon-style memory-mapped bus for both instruction fetch and data access.
- Boots from 0xBFC00000 and runs until it jumps to address 0, then halts and drops active.
- register_v0 exposes $2 for test observation.
- Sits at top level of the CPU; the bus connects to an external memory with one-cycle read latency.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- active  output  1  high while running; low once halted.
- register_v0  output  32  current contents of GPR $2.
- address  output  32  byte address, always word-aligned (bits [1:0]=0).
- write  output  1  write request.
- read  output  1  read request.
- waitrequest  input  1  slave stall; the request is held unchanged while high.
- writedata  output  32  store data.
- byteenable  output  4  lane enables; 4'b1111 for all implemented accesses.
- readdata  input  32  read data, valid the cycle after the accepting edge.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values while reset is asserted:
  - PC=RESET_VECTOR, nextPC=RESET_VECTOR+4.
  - All 32 GPRs=0; state=FETCH.
  - active=1, read=0, write=0, byteenable=4'b1111, writedata=0, address=PC.
- Bus rules:
  - read and write are never high together.
  - A request is accepted on a rising edge with waitrequest=0.
  - Read data is sampled at the next rising edge after acceptance.
  - address, writedata and byteenable are stable while the request is held.
- State machine:
  - FETCH:
    - If PC==0, go to HALT with no bus request.
    - Otherwise drive read=1, address=PC; stay while waitrequest=1; on acceptance go to EXEC.
  - EXEC:
    - Latch IR from readdata and decode/execute.
    - ALU, immediate, shift, branch and jump instructions write back here (rd, rt or $31) and go to FETCH.
    - LW and SW compute the effective address and go to MEM.
  - MEM:
    - Address = rs + sign-extended imm16.
    - LW: read=1; on acceptance go to WB.
    - SW: write=1, writedata=rt; on acceptance go to FETCH.
  - WB: write readdata into rt; go to FETCH.
  - HALT: active=0, read=0, write=0; stays until reset is asserted.
- PC and delay slot:
  - Every instruction completion sets PC<=nextPC.
  - Non-control instructions: nextPC<=nextPC+4.
  - Taken branch or jump: nextPC<=target, so the following instruction (delay slot) always executes.
  - Branch target = address of delay slot + (sign-extended imm16 << 2).
  - J/JAL target = {delay-slot PC[31:28], imm26, 2'b00}.
  - JAL/JALR link value = instruction PC + 8.
- Instruction set:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ.
  - J-type: J, JAL.
- Arithmetic and width rules:
  - ANDI, ORI and XORI zero-extend the immediate; all other immediates sign-extend.
  - LUI writes {imm16,16'h0}.
  - No overflow traps.
  - Writes to $0 are discarded; $0 always reads 0.
- Unimplemented opcodes execute as NOP (PC advances normally).
- register_v0 is combinational from GPR $2 and tracks writes immediately after the writing edge.
- Reset asserted mid-operation aborts any bus request immediately (read/write=0) and restarts from RESET_VECTOR.

Test Plan:
- Load/store round trip:
  - Program at 0xBFC00000: 3C08BFC0, 8D09002C, 00000008, AD090030; word 0xBFC0002C=0x0000A3F3.
  - Required: within 5000 cycles active=0 and word 0xBFC00030=0x0000A3F3 (delay-slot SW executed after JR $0).
- Reset release: reset held low 1 cycle, then released. Required: active=1 within one cycle; first bus op is read at 0xBFC00000.
- Register observation:
  - Program: LUI $2,0x1234; ORI $2,$2,0x5678; JR $0; NOP.
  - Required: register_v0=0x12345678 at halt.
- Wait states: waitrequest high for 3 cycles on every request. Required: address/read held constant throughout; same final results as the unstalled runs.
- Branch delay slot:
  - BEQ $0,$0,+2 followed by ADDIU $2,$0,1, with ADDIU $2,$2,4 at the skipped slot and ADDIU $2,$2,16 at the target.
  - Required: v0=17.
- Halt: after halt, read=write=0 for 100 cycles; asserting reset restarts fetch from 0xBFC00000.
